i2s_audio_tx: RTL and testbench

- Standalone I2S serializer that consumes the mixed/scaled 16-bit stereo audio produced by the video/audio output stage and drives the headphone/amplifier DAC pins (hp_bck, hp_ws, hp_din).
- Replaces the derived-clock I2S logic with a single-clock design: BCK is produced by a clock-enable divider, and samples arrive through a valid/ready handshake into a one-entry holding register.
- Supports Philips I2S framing with 32 BCK per frame, 16 bits per slot, and a mono-downmix mode.

---
 rtl/i2s_audio_tx.sv | 127 ++++++++++++
 tb/tb_i2s_audio_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - single-clock I2S serializer with BCK clock-enable divider and one-entry sample holding register
module i2s_audio_tx #(
    parameter int SAMPLE_W = 16,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                pll_lock,
    input  logic [DIV_W-1:0]    bck_div,
    input  logic                stereo,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                hp_bck,
    output logic                hp_ws,
    output logic                hp_din,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SAMPLE_W;

    logic [DIV_W-1:0]    div_cnt;
    logic [4:0]          bit_cnt;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [SAMPLE_W-1:0] last_l;
    logic [SAMPLE_W-1:0] last_r;
    logic [FRAME_W-1:0]  frame;

    logic                div_hit;
    logic                tick;
    logic                load;
    logic                accept;
    logic [4:0]          bit_nxt;
    logic [4:0]          bit_idx;
    logic [SAMPLE_W-1:0] src_l;
    logic [SAMPLE_W-1:0] src_r;
    logic [SAMPLE_W:0]   mono_sum;
    logic [SAMPLE_W-1:0] mono;
    logic [FRAME_W-1:0]  load_frame;
    logic [FRAME_W-1:0]  frame_nxt;
    logic                ws_nxt;

    // Holding register empty means the source may hand over the next pair.
    assign sample_ready = ~hold_full;

    // Divider compare, shift tick on the BCK falling toggle, and next-frame selection.
    always_comb begin
        div_hit    = (div_cnt >= bck_div);
        tick       = div_hit && hp_bck;
        bit_nxt    = bit_cnt + 5'd1;
        load       = tick && (bit_nxt == 5'd0);
        accept     = sample_valid && ~hold_full;
        src_l      = hold_full ? hold_l : last_l;
        src_r      = hold_full ? hold_r : last_r;
        mono_sum   = {src_l[SAMPLE_W-1], src_l} + {src_r[SAMPLE_W-1], src_r};
        mono       = mono_sum[SAMPLE_W:1];
        load_frame = stereo ? {src_l, src_r} : {mono, mono};
        frame_nxt  = load ? load_frame : frame;
        bit_idx    = 5'd31 - bit_nxt;
        // WS leads the slot by one BCK: high for bits 15..30.
        ws_nxt     = (bit_nxt >= 5'd15) && (bit_nxt != 5'd31);
    end

    // BCK generation: toggle whenever the counter reaches the half-period.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            div_cnt <= '0;
            hp_bck  <= 1'b0;
        end else if (div_hit) begin
            div_cnt <= '0;
            hp_bck  <= ~hp_bck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serial shifter: bit counter, WS and DIN change only on falling-BCK ticks.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            bit_cnt <= 5'd31;
            hp_ws   <= 1'b0;
            hp_din  <= 1'b0;
        end else if (tick) begin
            bit_cnt <= bit_nxt;
            hp_ws   <= ws_nxt;
            hp_din  <= frame_nxt[bit_idx];
        end
    end

    // Frame load: take the held pair, or repeat the previous one and flag an underrun.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            frame       <= '0;
            last_l      <= '0;
            last_r      <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && ~hold_full;
            if (load) begin
                frame  <= load_frame;
                last_l <= src_l;
                last_r <= src_r;
            end
        end
    end

    // Holding register: a new accept wins over the emptying done by a frame load.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= sample_l;
            hold_r    <= sample_r;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

    logic        clk;
    logic        pll_lock;
    logic [7:0]  bck_div;
    logic        stereo;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        hp_bck;
    logic        hp_ws;
    logic        hp_din;
    logic        frame_start;
    logic        underrun;

    int errors;
    int checks;
    int idx;
    logic streaming;

    logic [31:0] d;
    logic [31:0] w;
    int fs_seen;
    int ur_seen;
    int rdy_hi;
    int n;

    i2s_audio_tx #(.SAMPLE_W(16), .DIV_W(8)) dut (
        .clk          (clk),
        .pll_lock     (pll_lock),
        .bck_div      (bck_div),
        .stereo       (stereo),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .hp_bck       (hp_bck),
        .hp_ws        (hp_ws),
        .hp_din       (hp_din),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic acc;
        acc = sample_valid && sample_ready;
        @(posedge clk);
        #1;
        if (acc && streaming) begin
            idx++;
            sample_l = 16'(32'h1000 + idx);
            sample_r = 16'(32'h2000 + idx);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic wait_fs(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!frame_start && cnt < 2000);
        check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic capture(input int per, output logic [31:0] dd, output logic [31:0] ww,
                           output int fs, output int ur, output int rd);
        dd[31] = hp_din;
        ww[31] = hp_ws;
        fs = 0;
        ur = 0;
        rd = 0;
        for (int k = 30; k >= 0; k--) begin
            repeat (per) begin
                step();
                fs += int'(frame_start);
                ur += int'(underrun);
                rd += int'(sample_ready);
            end
            dd[k] = hp_din;
            ww[k] = hp_ws;
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        idx          = 0;
        streaming    = 1'b0;
        pll_lock     = 1'b0;
        bck_div      = 8'd3;
        stereo       = 1'b1;
        sample_l     = 16'h0000;
        sample_r     = 16'h0000;
        sample_valid = 1'b0;

        #12;
        check("rst_bck",   {31'd0, hp_bck},       32'd0);
        check("rst_ws",    {31'd0, hp_ws},        32'd0);
        check("rst_din",   {31'd0, hp_din},       32'd0);
        check("rst_fs",    {31'd0, frame_start},  32'd0);
        check("rst_ur",    {31'd0, underrun},     32'd0);
        check("rst_ready", {31'd0, sample_ready}, 32'd1);

        // Stereo frame: 8001/7FFE, BCK period 8 clk
        @(posedge clk);
        #1;
        pll_lock = 1'b1;
        offer(16'h8001, 16'h7FFE);
        check("ready_after_accept", {31'd0, sample_ready}, 32'd0);
        wait_fs(n);
        check("first_fs_latency", n, 32'd7);
        check("first_fs_ur",    {31'd0, underrun},     32'd0);
        check("first_fs_ws",    {31'd0, hp_ws},        32'd0);
        check("first_fs_ready", {31'd0, sample_ready}, 32'd1);
        check("first_fs_bck",   {31'd0, hp_bck},       32'd0);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("f1_data", d, 32'h8001_7FFE);
        check("f1_ws",   w, 32'h0001_FFFE);

        // No new sample: repeat and underrun once per frame
        wait_fs(n);
        check("f2_period", n, 32'd8);
        check("f2_ur", {31'd0, underrun}, 32'd1);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("f2_data",    d, 32'h8001_7FFE);
        check("f2_ws",      w, 32'h0001_FFFE);
        check("f2_fs_cnt",  fs_seen, 32'd0);
        check("f2_ur_cnt",  ur_seen, 32'd0);
        check("f2_rdy_cnt", rdy_hi, 32'd248);
        wait_fs(n);
        check("f3_period", n, 32'd8);
        check("f3_ur", {31'd0, underrun}, 32'd1);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("f3_data", d, 32'h8001_7FFE);

        // Mono downmix
        stereo = 1'b0;
        offer(16'h7FFF, 16'h7FFF);
        wait_fs(n);
        check("mono1_ur", {31'd0, underrun}, 32'd0);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("mono1_data", d, 32'h7FFF_7FFF);
        offer(16'h8000, 16'h7FFF);
        wait_fs(n);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("mono2_data", d, 32'hFFFF_FFFF);

        // Continuous valid with incrementing data
        stereo       = 1'b1;
        idx          = 0;
        sample_l     = 16'h1000;
        sample_r     = 16'h2000;
        streaming    = 1'b1;
        sample_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_fs(n);
            check("stream_ur",    {31'd0, underrun},     32'd0);
            check("stream_ready", {31'd0, sample_ready}, 32'd1);
            capture(8, d, w, fs_seen, ur_seen, rdy_hi);
            check("stream_data", d, {16'(32'h1000 + f), 16'(32'h2000 + f)});
            check("stream_rdy_cnt", rdy_hi, 32'd0);
            check("stream_ur_cnt",  ur_seen, 32'd0);
        end
        streaming    = 1'b0;
        sample_valid = 1'b0;

        // Reset mid-frame at bit_cnt 20 with a full holding register
        wait_fs(n);
        repeat (160) step();
        offer(16'hAAAA, 16'h5555);
        check("pre_rst_ready", {31'd0, sample_ready}, 32'd0);
        check("pre_rst_ws",    {31'd0, hp_ws},        32'd1);
        #2;
        pll_lock = 1'b0;
        #1;
        check("async_ws",    {31'd0, hp_ws},        32'd0);
        check("async_din",   {31'd0, hp_din},       32'd0);
        check("async_bck",   {31'd0, hp_bck},       32'd0);
        check("async_ready", {31'd0, sample_ready}, 32'd1);
        check("async_fs",    {31'd0, frame_start},  32'd0);
        @(posedge clk);
        #1;
        pll_lock = 1'b1;
        wait_fs(n);
        check("post_rst_latency", n, 32'd8);
        check("post_rst_ur", {31'd0, underrun}, 32'd1);
        check("post_rst_ws", {31'd0, hp_ws},    32'd0);
        capture(8, d, w, fs_seen, ur_seen, rdy_hi);
        check("post_rst_data", d, 32'h0000_0000);

        // Live bck_div decrease 10 -> 2 with div_cnt at 7
        pll_lock = 1'b0;
        bck_div  = 8'd10;
        step();
        pll_lock = 1'b1;
        repeat (18) step();
        check("div10_bck_high", {31'd0, hp_bck}, 32'd1);
        bck_div = 8'd2;
        step();
        check("div2_toggle", {31'd0, hp_bck},      32'd0);
        check("div2_fs",     {31'd0, frame_start}, 32'd1);
        repeat (3) step();
        check("div2_rise", {31'd0, hp_bck}, 32'd1);
        repeat (3) step();
        check("div2_fall", {31'd0, hp_bck}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
